// File: rtl/median_engine.sv
// rtl/median_engine.sv - raster-scan 3x3 median filter: window reads, 3-stage median pipeline, write-back
// Optional feature macro MEDIAN_BYPASS_EN adds a bypass input that forwards the window centre pixel.
module median_engine #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sw_pixel_1,
  input  logic [7:0] sw_pixel_2,
  input  logic [7:0] sw_pixel_3,
  input  logic [7:0] sw_pixel_4,
  input  logic [7:0] sw_pixel_5,
  input  logic [7:0] sw_pixel_6,
  input  logic [7:0] sw_pixel_7,
  input  logic [7:0] sw_pixel_8,
  input  logic [7:0] sw_pixel_9,
`ifdef MEDIAN_BYPASS_EN
  input  logic       bypass,
`endif
  output logic       rd,
  output logic [7:0] addr_row_r,
  output logic [7:0] addr_col_r,
  output logic       wr,
  output logic [7:0] addr_row_w,
  output logic [7:0] addr_col_w,
  output logic [7:0] cl_pixel,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_COL   = 8'(IMG_W - 3);
  localparam logic [7:0] LAST_ROW   = 8'(IMG_H - 3);
  localparam logic [7:0] DRAIN_LAST = 8'(MEM_LAT + 2);

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Packed as {hi, mid, lo}
  function automatic logic [23:0] sort3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {max2(max2(a, b), c), med3(a, b, c), min2(min2(a, b), c)};
  endfunction

  state_t      state;
  logic [7:0]  drain_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rd         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_row_r <= '0;
      addr_col_r <= '0;
      drain_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= SCAN;
          rd         <= 1'b1;
          busy       <= 1'b1;
          addr_row_r <= '0;
          addr_col_r <= '0;
        end
        SCAN: begin
          if (addr_col_r != LAST_COL) begin
            addr_col_r <= addr_col_r + 8'd1;
          end else if (addr_row_r != LAST_ROW) begin
            addr_col_r <= '0;
            addr_row_r <= addr_row_r + 8'd1;
          end else begin
            state     <= DRAIN;
            rd        <= 1'b0;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tags ride alongside the memory latency so they line up with sw_pixel_*
  logic [MEM_LAT-1:0] rv;
  logic [7:0]         rv_row [MEM_LAT];
  logic [7:0]         rv_col [MEM_LAT];
  logic               load;
  logic               s1_v, s2_v;
  logic [7:0]         s1_row, s1_col, s2_row, s2_col;
  logic [23:0]        s1_r0, s1_r1, s1_r2;
  logic [7:0]         s2_a, s2_b, s2_c;
  logic [7:0]         result;

  assign load = rv[MEM_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rv <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        rv_row[i] <= '0;
        rv_col[i] <= '0;
      end
      s1_v       <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
      s1_r0      <= '0;
      s1_r1      <= '0;
      s1_r2      <= '0;
      s2_v       <= 1'b0;
      s2_row     <= '0;
      s2_col     <= '0;
      s2_a       <= '0;
      s2_b       <= '0;
      s2_c       <= '0;
      wr         <= 1'b0;
      cl_pixel   <= '0;
      addr_row_w <= '0;
      addr_col_w <= '0;
    end else begin
      rv[0]     <= rd;
      rv_row[0] <= addr_row_r;
      rv_col[0] <= addr_col_r;
      for (int i = 1; i < MEM_LAT; i++) begin
        rv[i]     <= rv[i-1];
        rv_row[i] <= rv_row[i-1];
        rv_col[i] <= rv_col[i-1];
      end
      s1_v <= load;
      if (load) begin
        s1_row <= rv_row[MEM_LAT-1];
        s1_col <= rv_col[MEM_LAT-1];
        s1_r0  <= sort3(sw_pixel_1, sw_pixel_2, sw_pixel_3);
        s1_r1  <= sort3(sw_pixel_4, sw_pixel_5, sw_pixel_6);
        s1_r2  <= sort3(sw_pixel_7, sw_pixel_8, sw_pixel_9);
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_row <= s1_row;
        s2_col <= s1_col;
        s2_a   <= max2(max2(s1_r0[7:0], s1_r1[7:0]), s1_r2[7:0]);
        s2_b   <= med3(s1_r0[15:8], s1_r1[15:8], s1_r2[15:8]);
        s2_c   <= min2(min2(s1_r0[23:16], s1_r1[23:16]), s1_r2[23:16]);
      end
      wr <= s2_v;
      if (s2_v) begin
        cl_pixel   <= result;
        addr_row_w <= s2_row + 8'd1;
        addr_col_w <= s2_col + 8'd1;
      end
    end
  end

`ifdef MEDIAN_BYPASS_EN
  logic       s1_byp, s2_byp;
  logic [7:0] s1_ctr, s2_ctr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_byp <= 1'b0;
      s2_byp <= 1'b0;
      s1_ctr <= '0;
      s2_ctr <= '0;
    end else begin
      if (load) begin
        s1_byp <= bypass;
        s1_ctr <= sw_pixel_5;
      end
      if (s1_v) begin
        s2_byp <= s1_byp;
        s2_ctr <= s1_ctr;
      end
    end
  end

  assign result = s2_byp ? s2_ctr : med3(s2_a, s2_b, s2_c);
`else
  assign result = med3(s2_a, s2_b, s2_c);
`endif

endmodule

// File: tb/tb_median_engine.sv
// tb/tb_median_engine.sv - scoreboard bench for median_engine on an 8x8 and a 6-wide x 5-high instance
// Exercises the bypass input as well when MEDIAN_BYPASS_EN is defined.
module tb_median_engine;
  localparam int MEM_LAT = 2;
  localparam int K_UNI = 0, K_SALT = 1, K_PAT = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] rd_v, wr_v, busy_v, done_v;
  logic       clr = 1'b0;
  int         chk_mode = 0;
  int         kind = K_UNI;
  logic       byp = 1'b0;
  logic [7:0] img [8][8];
  logic [7:0] cap_a, cap_b;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // Reference median: full bubble sort of the nine pixels, or hand constants for flat frames
  function automatic logic [7:0] exp_pix(input int r, input int c);
    logic [7:0] v [9];
    logic [7:0] t;
    if (byp) return img[r+1][c+1];
    if (kind == K_UNI) return 8'h40;
    if (kind == K_SALT) return 8'h10;
    for (int k = 0; k < 9; k++) v[k] = img[r + k/3][c + k%3];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  task automatic build(input int k);
    logic [7:0] wa [9];
    logic [7:0] wb [9];
    wa = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    wb = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    kind = k;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (k)
          K_UNI:   img[r][c] = 8'h40;
          K_SALT:  img[r][c] = (r == 3 && c == 3) ? 8'hFF : 8'h10;
          default: img[r][c] = 8'(r * 37 + c * 91 + 13);
        endcase
    if (k == K_PAT)
      for (int i = 0; i < 9; i++) begin
        img[i/3][i%3]     = wa[i];
        img[i/3][4 + i%3] = wb[i];
      end
  endtask

  for (genvar G = 0; G < 2; G++) begin : g_dut
    localparam int W = (G == 0) ? 8 : 6;
    localparam int H = (G == 0) ? 8 : 5;
    localparam int NWIN = (W - 2) * (H - 2);

    logic [7:0] p [9];
    logic [7:0] rrow, rcol, wrow, wcol, pix;
    logic [7:0] d_row [MEM_LAT];
    logic [7:0] d_col [MEM_LAT];
    exp_t       q[$];
    exp_t       e;
    int cyc = 0, n_rd = 0, n_wr = 0, n_done = 0;
    int first_rd = 0, last_rd = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
    int exp_r = 0, exp_c = 0;

    median_engine #(.IMG_W(W), .IMG_H(H), .MEM_LAT(MEM_LAT)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[G]),
      .sw_pixel_1(p[0]), .sw_pixel_2(p[1]), .sw_pixel_3(p[2]),
      .sw_pixel_4(p[3]), .sw_pixel_5(p[4]), .sw_pixel_6(p[5]),
      .sw_pixel_7(p[6]), .sw_pixel_8(p[7]), .sw_pixel_9(p[8]),
`ifdef MEDIAN_BYPASS_EN
      .bypass(byp),
`endif
      .rd(rd_v[G]), .addr_row_r(rrow), .addr_col_r(rcol),
      .wr(wr_v[G]), .addr_row_w(wrow), .addr_col_w(wcol),
      .cl_pixel(pix), .busy(busy_v[G]), .done(done_v[G])
    );

    // Window memory: address registered MEM_LAT times, pixels looked up from the last stage
    always @(posedge clk) begin
      d_row[0] <= rrow;
      d_col[0] <= rcol;
      for (int i = 1; i < MEM_LAT; i++) begin
        d_row[i] <= d_row[i-1];
        d_col[i] <= d_col[i-1];
      end
    end

    always_comb
      for (int k = 0; k < 9; k++)
        p[k] = img[int'(d_row[MEM_LAT-1]) + k/3][int'(d_col[MEM_LAT-1]) + k%3];

    always @(negedge clk) begin
      cyc++;
      if (clr) begin
        q.delete();
        n_rd = 0; n_wr = 0; n_done = 0; exp_r = 0; exp_c = 0;
        for (int r = 0; r < H - 2; r++)
          for (int c = 0; c < W - 2; c++)
            q.push_back({8'(r + 1), 8'(c + 1), exp_pix(r, c)});
      end else if (!rst) begin
        q.delete();
        n_rd = 0; n_wr = 0; n_done = 0;
      end else begin
        if (rd_v[G]) begin
          chk($sformatf("dut%0d_raddr", G), int'({rrow, rcol}), exp_r * 256 + exp_c);
          if (n_rd == 0) first_rd = cyc;
          last_rd = cyc;
          n_rd++;
          if (exp_c == W - 3) begin
            exp_c = 0;
            exp_r++;
          end else exp_c++;
        end
        if (wr_v[G]) begin
          if (q.size() == 0) chk($sformatf("dut%0d_unexpected_wr", G), int'({wrow, wcol, pix}), -1);
          else begin
            e = q.pop_front();
            chk($sformatf("dut%0d_wr_row_col_pix", G), int'({wrow, wcol, pix}), int'(e));
          end
          if (n_wr == 0) first_wr = cyc;
          last_wr = cyc;
          n_wr++;
        end
        if (done_v[G]) begin
          n_done++;
          done_cyc = cyc;
        end
        if (chk_mode == 1) begin
          chk($sformatf("dut%0d_read_count", G), n_rd, NWIN);
          chk($sformatf("dut%0d_read_no_gap", G), last_rd - first_rd + 1, NWIN);
          chk($sformatf("dut%0d_write_count", G), n_wr, NWIN);
          chk($sformatf("dut%0d_writes_missing", G), q.size(), 0);
          chk($sformatf("dut%0d_rd_to_wr_latency", G), first_wr - first_rd, MEM_LAT + 3);
          chk($sformatf("dut%0d_done_count", G), n_done, 1);
          chk($sformatf("dut%0d_last_wr_to_done", G), done_cyc - last_wr, 1);
          chk($sformatf("dut%0d_busy_after_done", G), int'(busy_v[G]), 0);
        end else if (chk_mode == 2) begin
          chk($sformatf("dut%0d_wr_after_reset", G), n_wr, 0);
          chk($sformatf("dut%0d_done_after_reset", G), n_done, 0);
          chk($sformatf("dut%0d_rd_after_reset", G), n_rd, 0);
        end
      end
    end

    if (G == 0) begin : g_cap
      always @(negedge clk) begin
        if (clr) begin
          cap_a = 8'h00;
          cap_b = 8'h00;
        end else if (wr_v[0] && wrow == 8'd1 && wcol == 8'd1) cap_a = pix;
        else if (wr_v[0] && wrow == 8'd1 && wcol == 8'd5) cap_b = pix;
      end
    end
  end

  task automatic run_frame(input int k);
    build(k);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; start_v = 2'b11;
    @(posedge clk); #1 start_v = 2'b00;
  endtask

  task automatic frame_check(input int mode);
    #1 chk_mode = mode;
    @(negedge clk); #1 chk_mode = 0;
  endtask

  task automatic wait_frame();
    int t = 0;
    while (!(g_dut[0].n_done > 0 && g_dut[1].n_done > 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("frame_done_timeout", int'(t < 3000), 1);
    repeat (8) @(posedge clk);
    frame_check(1);
  endtask

  initial begin
    build(K_UNI);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd", int'(rd_v), 0);
    chk("reset_wr", int'(wr_v), 0);
    chk("reset_busy", int'(busy_v), 0);
    chk("reset_done", int'(done_v), 0);
    chk("reset_raddr", int'({g_dut[0].rrow, g_dut[0].rcol, g_dut[1].rrow, g_dut[1].rcol}), 0);
    chk("reset_waddr_pix", int'({g_dut[0].wrow, g_dut[0].wcol, g_dut[0].pix}), 0);
    rst = 1'b1;

    run_frame(K_UNI);
    wait_frame();
    run_frame(K_SALT);
    wait_frame();
    run_frame(K_PAT);
    wait_frame();
    chk("median_9_1_8_2_7_3_6_4_5", int'(cap_a), 5);
    chk("median_four_0_five_255", int'(cap_b), 255);

    // Extra starts: both mid-SCAN on dut0 / mid-DRAIN on dut1, then mid-DRAIN on dut0
    run_frame(K_PAT);
    repeat (13) @(posedge clk);
    #1 start_v = 2'b11;
    @(posedge clk); #1 start_v = 2'b00;
    repeat (23) @(posedge clk);
    #1 start_v = 2'b01;
    @(posedge clk); #1 start_v = 2'b00;
    wait_frame();

    // One-cycle reset while both instances are scanning and writing
    run_frame(K_UNI);
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midframe_reset_rd", int'(rd_v), 0);
    chk("midframe_reset_wr", int'(wr_v), 0);
    chk("midframe_reset_busy", int'(busy_v), 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (40) @(posedge clk);
    frame_check(2);
    run_frame(K_PAT);
    wait_frame();

`ifdef MEDIAN_BYPASS_EN
    byp = 1'b1;
    run_frame(K_SALT);
    wait_frame();
    byp = 1'b0;
    run_frame(K_SALT);
    wait_frame();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
